// File: rtl/nic_defs.sv
// Shared types and constants for the CCI-P TX flow scheduler.
package nic_defs;

   localparam int LMAX_CCIP_BATCH = 2;
   // TxGrant.flow_id is sized by this; keep it equal to the scheduler's LMAX_NUM_OF_FLOWS.
   localparam int TX_LMAX_FLOWS   = 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SCAN      = 2'd1,
      GRANT     = 2'd2,
      WAIT_DONE = 2'd3
   } TxSchedState;

   typedef struct packed {
      logic [TX_LMAX_FLOWS-1:0] flow_id;
      logic [1:0]               l_len;
   } TxGrant;

endpackage

// File: rtl/tx_flow_age_tracker.sv
// Per-flow saturating age counters; a flow is aged once it has waited flush_timeout cycles
// with data present. Counters clear on empty FIFO, on grant accept, or when the flow is inactive.
module tx_flow_age_tracker
#(
   parameter int LMAX_NUM_OF_FLOWS = 1,
   parameter int LTX_FIFO_DEPTH    = 3,
   parameter int AGE_W             = 16,
   localparam int MAX_TX_FLOWS     = 2**LMAX_NUM_OF_FLOWS,
   localparam int FW               = LTX_FIFO_DEPTH + 1
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
   input  logic [AGE_W-1:0]             flush_timeout,
   input  logic [MAX_TX_FLOWS*FW-1:0]   fill_level,
   input  logic                         clear_vld,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] clear_id,
   output logic [MAX_TX_FLOWS-1:0]      aged
);

   logic [AGE_W-1:0]        age_q [MAX_TX_FLOWS];
   logic [MAX_TX_FLOWS-1:0] hold_zero;

   always_comb begin
      hold_zero = '0;
      aged      = '0;
      for (int i = 0; i < MAX_TX_FLOWS; i++) begin
         hold_zero[i] = (fill_level[i*FW +: FW] == '0)
                     || (LMAX_NUM_OF_FLOWS'(i) > number_of_flows)
                     || (clear_vld && (clear_id == LMAX_NUM_OF_FLOWS'(i)));
         aged[i]      = (flush_timeout != '0) && (age_q[i] >= flush_timeout)
                     && (fill_level[i*FW +: FW] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_TX_FLOWS; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < MAX_TX_FLOWS; i++) begin
            if (hold_zero[i])          age_q[i] <= '0;
            else if (age_q[i] != '1)   age_q[i] <= age_q[i] + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ccip_tx_flow_scheduler.sv
// Round-robin TX flow scheduler: picks the next flow FIFO to drain and the batch length,
// flushing aged partial batches; new grants stall while CCI-P c1 is almost full.
module ccip_tx_flow_scheduler
   import nic_defs::*;
#(
   parameter int LMAX_NUM_OF_FLOWS = TX_LMAX_FLOWS,
   parameter int LTX_FIFO_DEPTH    = 3,
   parameter int AGE_W             = 16,
   localparam int MAX_TX_FLOWS     = 2**LMAX_NUM_OF_FLOWS,
   localparam int FW               = LTX_FIFO_DEPTH + 1
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
   input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
   input  logic [AGE_W-1:0]             flush_timeout,
   input  logic                         c1_almost_full,
   input  logic [MAX_TX_FLOWS*FW-1:0]   fill_level,
   output logic                         grant_valid,
   input  logic                         grant_ready,
   output logic [LMAX_NUM_OF_FLOWS-1:0] grant_flow_id,
   output logic [1:0]                   grant_l_len,
   input  logic                         grant_done,
   output logic                         busy,
   output logic [31:0]                  stat_flush_cnt
);

   TxSchedState                  state_q, state_d;
   TxGrant                       grant_q, grant_d;
   logic [LMAX_NUM_OF_FLOWS-1:0] ptr_q, ptr_d;
   logic [31:0]                  flush_cnt_q;
   logic                         flush_inc;
   logic                         accept;
   logic [MAX_TX_FLOWS-1:0]      aged;
   logic [FW-1:0]                fill_sel;
   logic [FW:0]                  batch_lines;
   logic                         fill_full;
   logic [1:0]                   partial_len;

   function automatic logic [LMAX_NUM_OF_FLOWS-1:0] next_flow(
      input logic [LMAX_NUM_OF_FLOWS-1:0] cur,
      input logic [LMAX_NUM_OF_FLOWS-1:0] last
   );
      return (cur >= last) ? '0 : cur + 1'b1;
   endfunction

   function automatic logic [1:0] floor_log2(input logic [FW-1:0] v);
      logic [1:0] r;
      r = '0;
      for (int b = 0; b < FW; b++) if (v[b]) r = 2'(b);
      return r;
   endfunction

   assign accept      = (state_q == GRANT) && grant_ready;
   assign fill_sel    = fill_level[ptr_q*FW +: FW];
   assign batch_lines = (FW+1)'(1) << l_tx_batch_size;
   assign fill_full   = ({1'b0, fill_sel} >= batch_lines);

   always_comb begin
      partial_len = floor_log2(fill_sel);
      if (partial_len > l_tx_batch_size) partial_len = l_tx_batch_size;
   end

   tx_flow_age_tracker #(
      .LMAX_NUM_OF_FLOWS (LMAX_NUM_OF_FLOWS),
      .LTX_FIFO_DEPTH    (LTX_FIFO_DEPTH),
      .AGE_W             (AGE_W)
   ) u_age (
      .clk             (clk),
      .reset           (reset),
      .number_of_flows (number_of_flows),
      .flush_timeout   (flush_timeout),
      .fill_level      (fill_level),
      .clear_vld       (accept),
      .clear_id        (grant_q.flow_id),
      .aged            (aged)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      flush_inc = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = SCAN;
         SCAN: begin
            if (!start) begin
               state_d = IDLE;
            end else if (c1_almost_full) begin
               state_d = SCAN;
            end else if (ptr_q > number_of_flows) begin
               // flow count shrank under the pointer: skip the now-inactive flow
               ptr_d = '0;
            end else if (fill_full) begin
               grant_d.flow_id = ptr_q;
               grant_d.l_len   = l_tx_batch_size;
               state_d         = GRANT;
            end else if (aged[ptr_q]) begin
               grant_d.flow_id = ptr_q;
               grant_d.l_len   = partial_len;
               flush_inc       = 1'b1;
               state_d         = GRANT;
            end else begin
               ptr_d = next_flow(ptr_q, number_of_flows);
            end
         end
         GRANT: if (grant_ready) state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (grant_done) begin
               ptr_d   = next_flow(grant_q.flow_id, number_of_flows);
               state_d = SCAN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign grant_valid    = (state_q == GRANT);
   assign busy           = (state_q == GRANT) || (state_q == WAIT_DONE);
   assign grant_flow_id  = grant_q.flow_id;
   assign grant_l_len    = grant_q.l_len;
   assign stat_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// Directed bench for the TX flow scheduler (2 flows, 4-bit fill levels).
module tb_ccip_tx_flow_scheduler;
   import nic_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [0:0]  number_of_flows;
   logic [1:0]  l_tx_batch_size;
   logic [15:0] flush_timeout;
   logic        c1_almost_full;
   logic [7:0]  fill_level;
   logic        grant_valid;
   logic        grant_ready;
   logic [0:0]  grant_flow_id;
   logic [1:0]  grant_l_len;
   logic        grant_done;
   logic        busy;
   logic [31:0] stat_flush_cnt;

   int checks   = 0;
   int failures = 0;
   bit seen;

   always #5 clk = ~clk;

   ccip_tx_flow_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .number_of_flows (number_of_flows),
      .l_tx_batch_size (l_tx_batch_size),
      .flush_timeout   (flush_timeout),
      .c1_almost_full  (c1_almost_full),
      .fill_level      (fill_level),
      .grant_valid     (grant_valid),
      .grant_ready     (grant_ready),
      .grant_flow_id   (grant_flow_id),
      .grant_l_len     (grant_l_len),
      .grant_done      (grant_done),
      .busy            (busy),
      .stat_flush_cnt  (stat_flush_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_fill(input logic [3:0] f0, input logic [3:0] f1);
      fill_level = {f1, f0};
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (!grant_valid && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(grant_valid), 32'd1);
   endtask

   task automatic accept_and_done(input logic [3:0] f0, input logic [3:0] f1);
      grant_ready = 1'b1;
      tick();
      grant_ready = 1'b0;
      set_fill(f0, f1);
      grant_done = 1'b1;
      tick();
      grant_done = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; number_of_flows = 1'b1; l_tx_batch_size = 2'd1;
      flush_timeout = 16'd0; c1_almost_full = 1'b0; fill_level = 8'h00;
      grant_ready = 1'b0; grant_done = 1'b0;
      tick(); tick();
      chk("rst_valid", 32'(grant_valid), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_flow",  32'(grant_flow_id), 32'd0);
      chk("rst_len",   32'(grant_l_len), 32'd0);
      chk("rst_flush", stat_flush_cnt, 32'd0);

      // 1: flow1 holds a full 2-line batch; flow0 empty
      reset = 1'b0; start = 1'b1; set_fill(4'd0, 4'd2);
      tick(); tick();
      chk("t1_early_valid", 32'(grant_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(grant_valid), 32'd1);
      chk("t1_flow",  32'(grant_flow_id), 32'd1);
      chk("t1_len",   32'(grant_l_len), 32'd1);
      chk("t1_busy",  32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t1_hold_valid", 32'(grant_valid), 32'd1);
         chk("t1_hold_fields", {29'd0, grant_flow_id, grant_l_len}, {29'd0, 1'b1, 2'd1});
      end
      grant_ready = 1'b1;
      tick();
      grant_ready = 1'b0;
      chk("t1_wait_valid", 32'(grant_valid), 32'd0);
      chk("t1_wait_busy",  32'(busy), 32'd1);
      set_fill(4'd0, 4'd0);
      grant_done = 1'b1;
      tick();
      grant_done = 1'b0;
      chk("t1_idle_busy", 32'(busy), 32'd0);

      // 2: both flows full at 4 lines -> strict alternation
      l_tx_batch_size = 2'd2; set_fill(4'd4, 4'd4);
      for (int k = 0; k < 4; k++) begin
         wait_grant("t2_grant");
         chk("t2_flow", 32'(grant_flow_id), 32'(k % 2));
         chk("t2_len",  32'(grant_l_len), 32'd2);
         accept_and_done(4'd4, 4'd4);
      end

      // 3: partial batch of 3 lines flushed once flow0 has aged 10 cycles
      set_fill(4'd0, 4'd0);
      tick(); tick();
      flush_timeout = 16'd10; set_fill(4'd3, 4'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (grant_valid) seen = 1'b1;
      end
      chk("t3_no_early_flush", 32'(seen), 32'd0);
      wait_grant("t3_grant");
      chk("t3_flow",  32'(grant_flow_id), 32'd0);
      chk("t3_len",   32'(grant_l_len), 32'd1);
      chk("t3_flush", stat_flush_cnt, 32'd1);
      accept_and_done(4'd0, 4'd0);
      flush_timeout = 16'd0; set_fill(4'd3, 4'd0);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (grant_valid) seen = 1'b1;
      end
      chk("t3_disabled", 32'(seen), 32'd0);

      // 4: c1 almost full blocks new grants but not an offered one
      c1_almost_full = 1'b1; set_fill(4'd4, 4'd4);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (grant_valid) seen = 1'b1;
      end
      chk("t4_stalled", 32'(seen), 32'd0);
      c1_almost_full = 1'b0;
      tick();
      chk("t4_release", 32'(grant_valid), 32'd1);
      c1_almost_full = 1'b1;
      tick(); tick(); tick();
      chk("t4_not_retracted", 32'(grant_valid), 32'd1);
      c1_almost_full = 1'b0;
      accept_and_done(4'd0, 4'd0);

      // 5: shrink to one flow while the pointer sits on flow1
      set_fill(4'd4, 4'd0);
      wait_grant("t5_grant0");
      chk("t5_flow0", 32'(grant_flow_id), 32'd0);
      accept_and_done(4'd0, 4'd4);
      number_of_flows = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (grant_valid) seen = 1'b1;
      end
      chk("t5_flow1_ignored", 32'(seen), 32'd0);
      chk("t5_age1_zero", 32'(dut.u_age.age_q[1]), 32'd0);
      l_tx_batch_size = 2'd1; set_fill(4'd2, 4'd4);
      wait_grant("t5_grant_wrap");
      chk("t5_flow_wrap", 32'(grant_flow_id), 32'd0);
      chk("t5_len_wrap",  32'(grant_l_len), 32'd1);
      grant_ready = 1'b1;
      tick();
      grant_ready = 1'b0;

      // 6: reset while waiting for done
      chk("t6_pre_busy",  32'(busy), 32'd1);
      chk("t6_pre_flush", stat_flush_cnt, 32'd1);
      reset = 1'b1;
      tick();
      chk("t6_valid", 32'(grant_valid), 32'd0);
      chk("t6_busy",  32'(busy), 32'd0);
      chk("t6_flush", stat_flush_cnt, 32'd0);
      chk("t6_state", 32'(dut.state_q), 32'(IDLE));
      chk("t6_fields", {29'd0, grant_flow_id, grant_l_len}, 32'd0);
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
